// File: rtl/clock_switch_n.sv
// Glitch-free NUM_CLK-way clock switch; clk_800 valid/ready select, old gate drained before new gate opens.
// Latency ~2*SYNC_STAGES source edges + 2*SYNC_STAGES+2 clk_800; ready low while busy. `CLK_SWITCH_TIMEOUT_EN adds stall timeout.
module clock_switch_n #(
  parameter int  NUM_CLK     = 4,
  parameter int  SYNC_STAGES = 2,
  parameter int  RST_SEL     = 0,
  parameter int  SCAN_CH     = NUM_CLK - 1,
  parameter int  TIMEOUT_CYC = 255,
  localparam int SEL_W       = $clog2(NUM_CLK)
) (
  input  logic               clk_800,
  input  logic               rst_clk_n,
  input  logic [NUM_CLK-1:0] clk_in,
  input  logic               sel_req_valid,
  input  logic [SEL_W-1:0]   sel_req_id,
  output logic               sel_req_ready,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               switch_busy,
  output logic               switch_err,
  output logic               clk_out,
  input  logic               dc_scan_mode,
  input  logic               icg_scan_mode,
  input  logic               clk_scan
);

  if (NUM_CLK < 2 || NUM_CLK > 16) begin : g_chk_num
    $error("clock_switch_n: NUM_CLK must be 2..16");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("clock_switch_n: SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_chk_to
    $error("clock_switch_n: TIMEOUT_CYC must fit the 8-bit counter");
  end
  if (RST_SEL >= NUM_CLK || SCAN_CH >= NUM_CLK) begin : g_chk_ch
    $error("clock_switch_n: RST_SEL/SCAN_CH out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ENABLE} state_t;

  localparam logic [SEL_W-1:0]   RST_ID     = SEL_W'(RST_SEL);
  localparam logic [NUM_CLK-1:0] RST_ONEHOT = {{(NUM_CLK-1){1'b0}}, 1'b1} << RST_SEL;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     target_q, target_d;
  logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
  logic [NUM_CLK-1:0]   en_req_q, en_req_d;
  logic                 err_q, err_d;
  logic [NUM_CLK-1:0]   en_sync;
  logic [NUM_CLK-1:0]   en_ack;
  logic [NUM_CLK-1:0]   gated;

`ifdef CLK_SWITCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT_CYC);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout;
  assign timeout = (cnt_q == TIMEOUT_L);
`endif

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cur_sel_d = cur_sel_q;
    en_req_d  = en_req_q;
    err_d     = 1'b0;
`ifdef CLK_SWITCH_TIMEOUT_EN
    cnt_d     = cnt_q + 8'd1;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_req_valid) begin
          if (int'(sel_req_id) >= NUM_CLK) begin
            err_d = 1'b1;
          end else if (sel_req_id != cur_sel_q) begin
            target_d            = sel_req_id;
            en_req_d[cur_sel_q] = 1'b0;
            state_d             = S_DRAIN;
`ifdef CLK_SWITCH_TIMEOUT_EN
            cnt_d               = 8'd0;
`endif
          end
        end
      end
      S_DRAIN: begin
        // A dead old clock never returns its ack; the timeout treats it as drained.
        if (!en_ack[cur_sel_q]) begin
          en_req_d[target_q] = 1'b1;
          state_d            = S_ENABLE;
`ifdef CLK_SWITCH_TIMEOUT_EN
          cnt_d              = 8'd0;
        end else if (timeout) begin
          err_d              = 1'b1;
          en_req_d[target_q] = 1'b1;
          state_d            = S_ENABLE;
          cnt_d              = 8'd0;
`endif
        end
      end
      S_ENABLE: begin
        if (en_ack[target_q]) begin
          cur_sel_d = target_q;
          state_d   = S_IDLE;
`ifdef CLK_SWITCH_TIMEOUT_EN
        end else if (timeout) begin
          err_d     = 1'b1;
          cur_sel_d = target_q;
          state_d   = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_800 or negedge rst_clk_n) begin
    if (!rst_clk_n) begin
      state_q   <= S_ENABLE;
      target_q  <= RST_ID;
      cur_sel_q <= RST_ID;
      en_req_q  <= RST_ONEHOT;
      err_q     <= 1'b0;
`ifdef CLK_SWITCH_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cur_sel_q <= cur_sel_d;
      en_req_q  <= en_req_d;
      err_q     <= err_d;
`ifdef CLK_SWITCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign sel_req_ready = (state_q == S_IDLE);
  assign switch_busy   = (state_q != S_IDLE);
  assign switch_err    = err_q;
  assign cur_sel       = cur_sel_q;

  for (genvar i = 0; i < NUM_CLK; i++) begin : g_ch
    logic                   ck;
    logic [SYNC_STAGES-1:0] fwd_q;
    logic [SYNC_STAGES-1:0] bwd_q;
    logic                   gate_en;
    logic                   lat_q;

    assign ck = dc_scan_mode ? clk_scan : clk_in[i];

    always_ff @(posedge ck or negedge rst_clk_n) begin
      if (!rst_clk_n) fwd_q <= '0;
      else            fwd_q <= {fwd_q[SYNC_STAGES-2:0], en_req_q[i]};
    end
    assign en_sync[i] = fwd_q[SYNC_STAGES-1];

    always_ff @(posedge clk_800 or negedge rst_clk_n) begin
      if (!rst_clk_n) bwd_q <= '0;
      else            bwd_q <= {bwd_q[SYNC_STAGES-2:0], en_sync[i]};
    end
    assign en_ack[i] = bwd_q[SYNC_STAGES-1];

    assign gate_en = en_sync[i] & (~dc_scan_mode | (i == SCAN_CH));

    // Latch is deliberately not reset: a high phase in flight finishes intact.
    always_latch begin
      if (!ck) lat_q <= gate_en | icg_scan_mode;
    end
    assign gated[i] = lat_q & ck;
  end

  assign clk_out = |gated;

endmodule

// File: tb/tb_clock_switch_n.sv
// Directed bench for clock_switch_n: five source clocks, scoreboard of expected cur_sel/err per request,
// pulse-width monitor on clk_out, reset-in-DRAIN, stalled-clock and scan-mode steps.
module tb_clock_switch_n;

  localparam int MINW = 500;

  logic       clk_800, rst_clk_n;
  logic       ck0, ck1, ck2, ck3, ck4, stop2, clk_scan;
  logic [4:0] clk_in;
  logic       sel_req_valid, sel_req_ready;
  logic [2:0] sel_req_id, cur_sel;
  logic       switch_busy, switch_err, clk_out;
  logic       dc_scan_mode, icg_scan_mode;
  logic [5:0] clk_vec;

  int total = 0;
  int bad   = 0;
  logic [2:0] sel_exp_q[$];
  logic       err_exp_q[$];

  logic mon_en = 1'b0;
  time  t_rise = 0, t_fall = 0;
  time  min_hi = 64'd1000000, min_lo = 64'd1000000;

  assign clk_in  = {ck4, ck3, ck2, ck1, ck0};
  assign clk_vec = {clk_scan, clk_in};

  clock_switch_n #(.NUM_CLK(5), .SYNC_STAGES(2), .RST_SEL(0), .SCAN_CH(4), .TIMEOUT_CYC(255)) dut (
    .clk_800(clk_800), .rst_clk_n(rst_clk_n), .clk_in(clk_in),
    .sel_req_valid(sel_req_valid), .sel_req_id(sel_req_id), .sel_req_ready(sel_req_ready),
    .cur_sel(cur_sel), .switch_busy(switch_busy), .switch_err(switch_err), .clk_out(clk_out),
    .dc_scan_mode(dc_scan_mode), .icg_scan_mode(icg_scan_mode), .clk_scan(clk_scan)
  );

  initial begin clk_800 = 0; forever #625 clk_800 = ~clk_800; end
  initial begin ck0 = 0; #300; forever #625 ck0 = ~ck0; end
  initial begin ck1 = 0; #100; forever #1000 ck1 = ~ck1; end
  initial begin ck2 = 0; #50;  forever begin #500; ck2 = stop2 ? 1'b0 : ~ck2; end end
  initial begin ck3 = 0; #175; forever #1500 ck3 = ~ck3; end
  initial begin ck4 = 0; #225; forever #1250 ck4 = ~ck4; end
  initial begin clk_scan = 0; #400; forever #5000 clk_scan = ~clk_scan; end

  always @(posedge clk_out) begin
    if (mon_en && ($time - t_fall) < min_lo) min_lo = $time - t_fall;
    t_rise = $time;
  end
  always @(negedge clk_out) begin
    if (mon_en && ($time - t_rise) < min_hi) min_hi = $time - t_rise;
    t_fall = $time;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_widths(input string tag);
    chk({tag, "_min_high"}, 32'(min_hi >= MINW), 32'd1);
    chk({tag, "_min_low"},  32'(min_lo >= MINW), 32'd1);
  endtask

  task automatic follow(input int ch, input logic on, input string tag);
    for (int k = 0; k < 3; k++) begin
      wait (clk_vec[ch] === 1'b0);
      wait (clk_vec[ch] === 1'b1);
      #100 chk({tag, "_hi"}, clk_out, on);
      wait (clk_vec[ch] === 1'b0);
      #100 chk({tag, "_lo"}, clk_out, 1'b0);
    end
  endtask

  task automatic issue(input logic [2:0] id);
    int n = 0;
    @(negedge clk_800);
    sel_req_valid = 1'b1;
    sel_req_id    = id;
    while (sel_req_ready !== 1'b1 && n < 100) begin
      @(negedge clk_800);
      n++;
    end
    chk("accept", sel_req_ready, 1'b1);
    @(negedge clk_800);
    sel_req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [2:0] id, input logic [2:0] exp_sel, input logic exp_err,
                        input logic is_switch, input int limit, output int err_at);
    int   n;
    logic seen;
    sel_exp_q.push_back(exp_sel);
    err_exp_q.push_back(exp_err);
    issue(id);
    if (is_switch) begin
      chk("ready_drop", sel_req_ready, 1'b0);
      chk("busy_set", switch_busy, 1'b1);
    end else begin
      chk("busy_noswitch", switch_busy, 1'b0);
    end
    seen = 1'b0; err_at = -1; n = 0;
    while (n < limit) begin
      if (switch_err === 1'b1 && !seen) begin seen = 1'b1; err_at = n; end
      if (sel_req_ready === 1'b1) break;
      @(negedge clk_800);
      n++;
    end
    chk("done_ready", sel_req_ready, 1'b1);
    chk("done_busy", switch_busy, 1'b0);
    chk("cur_sel", cur_sel, sel_exp_q.pop_front());
    chk("err_seen", seen, err_exp_q.pop_front());
    @(negedge clk_800);
    chk("err_clear", switch_err, 1'b0);
  endtask

  initial begin
    int err_at;
    int n;
    rst_clk_n = 1'b1; sel_req_valid = 1'b0; sel_req_id = '0;
    dc_scan_mode = 1'b0; icg_scan_mode = 1'b0; stop2 = 1'b0;
    #1 rst_clk_n = 1'b0;

    repeat (4) @(negedge clk_800);
    chk("rst_ready", sel_req_ready, 1'b0);
    chk("rst_busy", switch_busy, 1'b1);
    chk("rst_err", switch_err, 1'b0);
    chk("rst_cur_sel", cur_sel, 3'd0);
    #7;
    for (int k = 0; k < 6; k++) begin chk("rst_clk_out", clk_out, 1'b0); #150; end
    mon_en = 1'b1;

    @(negedge clk_800) rst_clk_n = 1'b1;
    @(negedge clk_800) chk("rel_ready_hold", sel_req_ready, 1'b0);
    n = 0;
    while (sel_req_ready !== 1'b1 && n < 60) begin @(negedge clk_800); n++; end
    chk("rel_ready", sel_req_ready, 1'b1);
    chk("rel_busy", switch_busy, 1'b0);
    chk("rel_cur_sel", cur_sel, 3'd0);
    follow(0, 1'b1, "follow_ch0");

    do_req(3'd2, 3'd2, 1'b0, 1'b1, 200, err_at);
    follow(2, 1'b1, "follow_ch2");
    chk_widths("sw_0_to_2");

    do_req(3'd2, 3'd2, 1'b0, 1'b0, 200, err_at);
    follow(2, 1'b1, "noop_ch2");
    do_req(3'd5, 3'd2, 1'b1, 1'b0, 200, err_at);
    chk("bad_id_err_cycle", err_at, 0);
    follow(2, 1'b1, "bad_id_ch2");

    stop2 = 1'b1;
    repeat (4) @(negedge clk_800);
`ifdef CLK_SWITCH_TIMEOUT_EN
    do_req(3'd1, 3'd1, 1'b1, 1'b1, 600, err_at);
    chk("timeout_window", 32'(err_at >= 250 && err_at <= 262), 32'd1);
    follow(1, 1'b1, "timeout_ch1");
    issue(3'd3);
    chk("drain_busy", switch_busy, 1'b1);
`else
    issue(3'd1);
    chk("stall_busy", switch_busy, 1'b1);
    repeat (300) @(negedge clk_800);
    chk("stall_busy_held", switch_busy, 1'b1);
    chk("stall_ready_low", sel_req_ready, 1'b0);
    chk("stall_cur_sel", cur_sel, 3'd2);
    chk("stall_clk_out", clk_out, 1'b0);
`endif
    chk_widths("pre_reset");

    #200 rst_clk_n = 1'b0;
    #1;
    chk("mid_rst_busy", switch_busy, 1'b1);
    chk("mid_rst_ready", sel_req_ready, 1'b0);
    chk("mid_rst_cur_sel", cur_sel, 3'd0);
    stop2 = 1'b0;
    repeat (10) @(negedge clk_800);
    #7;
    for (int k = 0; k < 6; k++) begin chk("mid_rst_clk_out", clk_out, 1'b0); #150; end
    @(negedge clk_800) rst_clk_n = 1'b1;
    n = 0;
    while (sel_req_ready !== 1'b1 && n < 60) begin @(negedge clk_800); n++; end
    chk("rerel_ready", sel_req_ready, 1'b1);
    chk("rerel_cur_sel", cur_sel, 3'd0);
    follow(0, 1'b1, "rerel_ch0");
    chk_widths("after_mid_reset");

    do_req(3'd4, 3'd4, 1'b0, 1'b1, 200, err_at);
    follow(4, 1'b1, "follow_ch4");
    chk_widths("sw_0_to_4");

    mon_en = 1'b0;
    dc_scan_mode = 1'b1;
    repeat (30) @(negedge clk_800);
    follow(5, 1'b1, "dc_scan_pass");
    do_req(3'd1, 3'd1, 1'b0, 1'b1, 600, err_at);
    follow(5, 1'b0, "dc_scan_block");

    dc_scan_mode  = 1'b0;
    icg_scan_mode = 1'b1;
    repeat (20) @(negedge clk_800);
    #7;
    for (int k = 0; k < 20; k++) begin chk("icg_transparent", clk_out, |clk_in); #150; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
